syscall_ctrl: RTL and testbench

Sequencer between the processor's syscall issue point and the console/system side. It accepts display/exit syscalls over a valid/ready handshake, buffers display values in a small FIFO drained to the console sink, and on exit drains all pending output before raising a sticky halt for the testbench to end simulation. It replaces direct single-cycle display/finish handling with backpressure to the processor.

---
 rtl/syscall_ctrl.sv | 130 +++++++++++++
 tb/tb_syscall_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/syscall_ctrl.sv
// ============================================================================
// Module   : syscall_ctrl
// Purpose  : Syscall sequencer with display FIFO, console drain and sticky halt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module syscall_ctrl #(
    parameter int                 DEPTH        = 4,
    parameter int                 DATA_W       = 32,
    parameter logic [DATA_W-1:0]  CODE_DISPLAY = DATA_W'(1),
    parameter logic [DATA_W-1:0]  CODE_EXIT    = DATA_W'(10)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [DATA_W-1:0]         req_code,
    input  logic [DATA_W-1:0]         req_arg,
    output logic                      con_valid,
    output logic [DATA_W-1:0]         con_data,
    input  logic                      con_ready,
    output logic [$clog2(DEPTH):0]    count,
    output logic [31:0]               disp_cnt,
    output logic                      err,
    output logic                      halt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [31:0]         disp_cnt_q, disp_cnt_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];

    logic                w_accept;
    logic                w_push;
    logic                w_pop;

    // Ready depends only on registered state so the processor sees no
    // combinational path from its own valid or from the console side.
    assign req_ready = (state_q == ST_RUN) && (count_q != CNT_W'(DEPTH));
    assign con_valid = (count_q != '0);
    assign con_data  = mem_q[head_q];
    assign count     = count_q;
    assign disp_cnt  = disp_cnt_q;
    assign err       = err_q;
    assign halt      = (state_q == ST_HALTED);

    assign w_accept  = req_valid && req_ready;
    assign w_push    = w_accept && (req_code == CODE_DISPLAY);
    assign w_pop     = con_valid && con_ready;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        disp_cnt_d = disp_cnt_q;
        err_d      = 1'b0;
        mem_d      = mem_q;

        if (w_push) begin
            mem_d[tail_q] = req_arg;
            tail_d        = tail_q + PTR_W'(1);
        end

        if (w_pop) begin
            head_d     = head_q + PTR_W'(1);
            disp_cnt_d = disp_cnt_q + 32'd1;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_RUN: begin
                if (w_accept && (req_code == CODE_EXIT)) begin
                    state_d = ST_DRAIN;
                end else if (w_accept && !w_push) begin
                    err_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (count_q == '0) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            disp_cnt_q <= '0;
            err_q      <= 1'b0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            disp_cnt_q <= disp_cnt_d;
            err_q      <= err_d;
            mem_q      <= mem_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_syscall_ctrl.sv
// ============================================================================
// Module   : tb_syscall_ctrl
// Purpose  : Directed and randomized checking of syscall_ctrl against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_syscall_ctrl;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_code;
    logic [31:0]       req_arg;
    logic              con_valid;
    logic [31:0]       con_data;
    logic              con_ready;
    logic [2:0]        count;
    logic [31:0]       disp_cnt;
    logic              err;
    logic              halt;

    syscall_ctrl #(
        .DEPTH        (DEPTH),
        .DATA_W       (DATA_W),
        .CODE_DISPLAY (32'd1),
        .CODE_EXIT    (32'd10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_code  (req_code),
        .req_arg   (req_arg),
        .con_valid (con_valid),
        .con_data  (con_data),
        .con_ready (con_ready),
        .count     (count),
        .disp_cnt  (disp_cnt),
        .err       (err),
        .halt      (halt)
    );

    always #5 clk = ~clk;

    // Reference model: pending console words, mode 0=run 1=drain 2=halted.
    logic [31:0] m_q[$];
    int          m_mode;
    logic [31:0] m_dcnt;
    logic        m_err;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return (m_mode == 0) && (m_q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_mode = 0;
        m_dcnt = '0;
        m_err  = 1'b0;
    endtask

    task automatic check_outputs();
        chk("req_ready", {31'd0, req_ready}, {31'd0, m_ready()});
        chk("con_valid", {31'd0, con_valid}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) chk("con_data", con_data, m_q[0]);
        chk("count", {29'd0, count}, 32'(m_q.size()));
        chk("disp_cnt", disp_cnt, m_dcnt);
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("halt", {31'd0, halt}, {31'd0, m_mode == 2});
    endtask

    // Called at a falling edge: check, apply inputs, advance model, wait one cycle.
    task automatic step(input logic v, input logic [31:0] code, input logic [31:0] arg,
                        input logic cr);
        logic acc;
        logic pop;
        int   pre_size;
        check_outputs();
        req_valid = v;
        req_code  = code;
        req_arg   = arg;
        con_ready = cr;
        pre_size  = m_q.size();
        acc       = v && m_ready();
        pop       = (pre_size != 0) && cr;
        m_err     = acc && (code != 32'd1) && (code != 32'd10);
        if (pop) begin
            void'(m_q.pop_front());
            m_dcnt = m_dcnt + 32'd1;
        end
        if (acc && code == 32'd1) m_q.push_back(arg);
        if (m_mode == 1 && pre_size == 0) m_mode = 2;
        else if (acc && code == 32'd10) m_mode = 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        con_ready = 1'b0;
        #1;
        model_reset();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_con_valid", {31'd0, con_valid}, 32'd0);
        chk("rst_con_data", con_data, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_disp_cnt", disp_cnt, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] code;
        int          r;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_code  = '0;
        req_arg   = '0;
        con_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Three displays streamed straight through.
        step(1, 1, 32'h11, 1);
        step(1, 1, 32'h22, 1);
        step(1, 1, 32'h33, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        // Backpressure: five offered into four entries, then release.
        for (int i = 0; i < 5; i++) step(1, 1, 32'hA0 + i, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 32'hA4, 0);
        step(1, 1, 32'hA4, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

        // Two displays then exit while console stalled.
        step(1, 1, 32'hB0, 0);
        step(1, 1, 32'hB1, 0);
        step(1, 10, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 32'hDEAD, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        do_reset();

        // Illegal code followed by a normal display.
        step(1, 7, 32'h55, 0);
        step(1, 1, 32'h66, 0);
        step(0, 0, 0, 0);

        // Simultaneous push and pop at occupancy two.
        step(1, 1, 32'h77, 0);
        step(1, 1, 32'h88, 1);
        step(1, 1, 32'h99, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

        // Reset while draining with three words pending.
        step(1, 1, 32'hC0, 0);
        step(1, 1, 32'hC1, 0);
        step(1, 1, 32'hC2, 0);
        step(1, 10, 0, 0);
        step(0, 0, 0, 0);
        do_reset();

        // Randomized episodes, some ending in halt, each closed by reset.
        for (int e = 0; e < 20; e++) begin
            for (int c = 0; c < 50; c++) begin
                r = $urandom_range(0, 31);
                if (r == 0) code = 32'd10;
                else if (r < 4) begin
                    code = $urandom;
                    if (code == 32'd1 || code == 32'd10) code = 32'd7;
                end else code = 32'd1;
                step(($urandom_range(0, 3) != 0), code, $urandom,
                     ($urandom_range(0, 2) != 0));
            end
            do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
